// File: rtl/kw_reset_seq.sv
// -----------------------------------------------------------------------------
// kw_reset_seq
//
// Ordered reset-release sequencer. It sits directly after the reset
// synchronizer. All NUM_OUTS subsystem resets are asserted together and held
// for HOLD_CYCLES. They are then released one at a time in index order. Each
// stage waits for its own programmable delay, and in the ack build also for a
// per-stage acknowledge. A software request re-runs the whole sequence
// without touching the upstream reset.
//
// Configuration macro:
//   KW_RESET_SEQ_ACK_EN  defined     -> WAIT_ACK state, ack timeout and the
//                                       sticky o_ack_err are built.
//                        not defined -> stages advance back-to-back, i_ack is
//                                       ignored and o_ack_err is tied low.
//
// Parameters:
//   NUM_OUTS     number of sequenced reset outputs (>= 1)
//   DELAY_W      width of each per-stage delay field
//   HOLD_CYCLES  cycles all outputs stay asserted before stage 0 (>= 1)
//   ACK_TIMEOUT  max cycles to wait for a stage ack (ack build, >= 1)
//
// Ports:
//   clock           destination clock
//   i_reset_n       async-assert, active-low reset (synchronizer output)
//   testmode        scan bypass: o_reset_n follows i_reset_n combinationally
//   i_sw_reset_req  software re-sequence request, sampled every edge
//   i_delay         stage k delay at [k*DELAY_W +: DELAY_W], stable while busy
//   i_ack           stage k out-of-reset acknowledge (ack build only)
//   o_reset_n       sequenced active-low resets
//   o_busy          sequence in progress
//   o_done          all stages released
//   o_ack_err       sticky: some stage ack timed out (cleared by i_reset_n)
// -----------------------------------------------------------------------------
module kw_reset_seq #(
    parameter int NUM_OUTS    = 4,
    parameter int DELAY_W     = 8,
    parameter int HOLD_CYCLES = 16,
    parameter int ACK_TIMEOUT = 255
) (
    input  logic                         clock,
    input  logic                         i_reset_n,
    input  logic                         testmode,
    input  logic                         i_sw_reset_req,
    input  logic [NUM_OUTS*DELAY_W-1:0]  i_delay,
    input  logic [NUM_OUTS-1:0]          i_ack,
    output logic [NUM_OUTS-1:0]          o_reset_n,
    output logic                         o_busy,
    output logic                         o_done,
    output logic                         o_ack_err
);

    // The counter must cover the longest thing it ever times: the hold
    // period, the largest programmable delay and the ack timeout.
    localparam int HOLD_LAST = HOLD_CYCLES - 1;
    localparam int DELAY_MAX = (1 << DELAY_W) - 1;
    localparam int MAX_HD    = (HOLD_LAST > DELAY_MAX) ? HOLD_LAST : DELAY_MAX;
    localparam int CNT_MAX   = (MAX_HD > ACK_TIMEOUT) ? MAX_HD : ACK_TIMEOUT;
    localparam int CNT_W     = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX + 1);
    localparam int K_W       = (NUM_OUTS < 2) ? 1 : $clog2(NUM_OUTS);

    localparam logic [K_W-1:0]   K_LAST        = K_W'(NUM_OUTS - 1);
    localparam logic [CNT_W-1:0] CNT_HOLD_LAST = CNT_W'(HOLD_LAST);
`ifdef KW_RESET_SEQ_ACK_EN
    localparam logic [CNT_W-1:0] CNT_ACK_LAST  = CNT_W'(ACK_TIMEOUT - 1);
`endif

`ifdef KW_RESET_SEQ_ACK_EN
    typedef enum logic [1:0] {
        ST_HOLD     = 2'd0,
        ST_REL      = 2'd1,
        ST_WAIT_ACK = 2'd2,
        ST_DONE     = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_HOLD = 2'd0,
        ST_REL  = 2'd1,
        ST_DONE = 2'd3
    } state_t;
`endif

    state_t               state_q, state_d;
    logic [K_W-1:0]       k_q, k_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [NUM_OUTS-1:0]  rst_q, rst_d;

    logic [DELAY_W-1:0]   cur_delay;
    logic [NUM_OUTS-1:0]  stage_bit;
    logic [CNT_W-1:0]     cnt_inc;
    logic                 last_stage;

`ifdef KW_RESET_SEQ_ACK_EN
    logic                 err_q, err_d;
    logic                 cur_ack;
`endif

    // -------------------------------------------------------------------------
    // Current-stage selection. The stage index is decoded by comparison
    // instead of a variable part-select, so NUM_OUTS=1 needs no special case.
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every variable driven here gets a default first, so no path
        // can leave it holding its old value and infer a latch.
        cur_delay = '0;
        stage_bit = '0;
`ifdef KW_RESET_SEQ_ACK_EN
        cur_ack   = 1'b0;
`endif
        for (int i = 0; i < NUM_OUTS; i++) begin
            if (k_q == K_W'(i)) begin
                cur_delay    = i_delay[i*DELAY_W +: DELAY_W];
                stage_bit[i] = 1'b1;
`ifdef KW_RESET_SEQ_ACK_EN
                cur_ack      = i_ack[i];
`endif
            end
        end
    end

    assign cnt_inc    = cnt_q + CNT_W'(1);
    assign last_stage = (k_q == K_LAST);

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        cnt_d   = cnt_q;
        rst_d   = rst_q;
`ifdef KW_RESET_SEQ_ACK_EN
        err_d   = err_q;
`endif

        case (state_q)
            ST_HOLD: begin
                if (cnt_q == CNT_HOLD_LAST) begin
                    state_d = ST_REL;
                    k_d     = '0;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end

            ST_REL: begin
                if (cnt_q == CNT_W'(cur_delay)) begin
                    // Released bits are OR-ed in, so they only fall again
                    // when the sequence goes back to HOLD.
                    rst_d = rst_q | stage_bit;
`ifdef KW_RESET_SEQ_ACK_EN
                    state_d = ST_WAIT_ACK;
                    cnt_d   = '0;
`else
                    if (last_stage) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_REL;
                        k_d     = k_q + K_W'(1);
                        cnt_d   = '0;
                    end
`endif
                end else begin
                    cnt_d = cnt_inc;
                end
            end

`ifdef KW_RESET_SEQ_ACK_EN
            ST_WAIT_ACK: begin
                if (cur_ack || (cnt_q == CNT_ACK_LAST)) begin
                    // An ack arriving on the timeout cycle still counts as a
                    // good ack.
                    if (!cur_ack) begin
                        err_d = 1'b1;
                    end
                    if (last_stage) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_REL;
                        k_d     = k_q + K_W'(1);
                        cnt_d   = '0;
                    end
                end else begin
                    cnt_d = cnt_inc;
                end
            end
`endif

            ST_DONE: begin
                rst_d = '1;
            end

            default: begin
                state_d = ST_HOLD;
                k_d     = '0;
                cnt_d   = '0;
                rst_d   = '0;
            end
        endcase

        // A software request wins over any same-edge transition, including a
        // release or entry to DONE. It does not clear the sticky ack error.
        // A timeout on the same edge is dropped with the rest of that
        // transition.
        if (i_sw_reset_req) begin
            state_d = ST_HOLD;
            k_d     = '0;
            cnt_d   = '0;
            rst_d   = '0;
`ifdef KW_RESET_SEQ_ACK_EN
            err_d   = err_q;
`endif
        end
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    // NOTE: asynchronous reset puts every output into its asserted state at
    // once. Deassertion is already synchronous because the upstream
    // synchronizer drives i_reset_n.
    always_ff @(posedge clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q <= ST_HOLD;
            k_q     <= '0;
            cnt_q   <= '0;
            rst_q   <= '0;
`ifdef KW_RESET_SEQ_ACK_EN
            err_q   <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking assignments make all registers update
            // together from this edge's values, with no ordering races.
            state_q <= state_d;
            k_q     <= k_d;
            cnt_q   <= cnt_d;
            rst_q   <= rst_d;
`ifdef KW_RESET_SEQ_ACK_EN
            err_q   <= err_d;
`endif
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    // In scan mode the reset tree is controlled directly by the tester.
    assign o_reset_n = testmode ? {NUM_OUTS{i_reset_n}} : rst_q;
    assign o_busy    = (state_q != ST_DONE);
    assign o_done    = (state_q == ST_DONE);

`ifdef KW_RESET_SEQ_ACK_EN
    assign o_ack_err = err_q;
`else
    assign o_ack_err = 1'b0;

    // The acknowledge inputs have no function in this build.
    logic unused_ack;
    assign unused_ack = ^i_ack;
`endif

endmodule
